cu_state_sequencer: RTL

Multi-cycle control-unit sequencer: holds the CPU's current instruction state and exchanges a two-phase trigger handshake with the next-state logic. It latches the returned next-state code and decodes the current state into datapath control strobes. It stalls on memory, counts cycles and retired instructions, and sits between the next-state logic and the datapath (PC, IR, register file, ALU, memory port).

---
 rtl/cu_state_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cu_state_sequencer.sv
// Multi-cycle control-unit sequencer.
// Each state runs an EXEC phase, where its controls are driven, and then a LATCH phase.
// EXEC toggles trigger as it ends; LATCH keeps all controls low and samples next_state.
// EXEC of IF, MEMLW and MEMSW stretches until mem_ready.
module cu_state_sequencer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       next_state,
    input  logic             mem_ready,
    output logic [3:0]       state,
    output logic             trigger,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_en,
    output logic             alu_src_imm,
    output logic             branch_eval,
    output logic             jump_en,
    output logic [1:0]       wb_sel,
    output logic [1:0]       dst_sel,
    output logic             retire,
    output logic             illegal_state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        StInit  = 4'd0,
        StIf    = 4'd1,
        StId    = 4'd2,
        StExeR  = 4'd3,
        StExeI  = 4'd4,
        StExeW  = 4'd5,
        StExeB  = 4'd6,
        StWbR   = 4'd7,
        StWbI   = 4'd8,
        StMemLw = 4'd9,
        StMemSw = 4'd10,
        StWbLw  = 4'd11,
        StWbJar = 4'd12
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic             phase_q, phase_d;   // 0 = EXEC, 1 = LATCH
    logic             trigger_q, trigger_d;
    logic             retire_q, retire_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;

    logic stall_state;
    logic exec_done;
    logic code_legal;

    // Next-state: phase sequencing, trigger toggle, state latch, pulses and counters
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        trigger_d   = trigger_q;
        retire_d    = 1'b0;
        illegal_d   = 1'b0;
        cycle_d     = cycle_q + CntOne;
        instr_d     = instr_q;
        stall_state = (state_q == StIf) || (state_q == StMemLw) || (state_q == StMemSw);
        exec_done   = !phase_q && (!stall_state || mem_ready);
        code_legal  = (next_state <= 4'(StWbJar));

        if (exec_done) begin
            phase_d   = 1'b1;
            trigger_d = ~trigger_q;
        end else if (phase_q) begin
            phase_d   = 1'b0;
            illegal_d = !code_legal;
            state_d   = code_legal ? state_e'(next_state) : StIf;
            // Returning to fetch means an instruction completed, unless coming out of boot
            if (state_d == StIf && state_q != StInit) begin
                retire_d = 1'b1;
                instr_d  = instr_q + CntOne;
            end
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StInit;
            phase_q   <= 1'b0;
            trigger_q <= 1'b0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            cycle_q   <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            trigger_q <= trigger_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
        end
    end

    // Control decode: only in EXEC, from the registered state (plus mem_ready for completion)
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mdr_write   = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_en      = 1'b0;
        alu_src_imm = 1'b0;
        branch_eval = 1'b0;
        jump_en     = 1'b0;
        wb_sel      = 2'b00;
        dst_sel     = 2'b00;
        if (!phase_q) begin
            unique case (state_q)
                StInit: ;
                StIf: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                StId:   jump_en = 1'b1;
                StExeR: alu_en = 1'b1;
                StExeI, StExeW: begin
                    alu_en      = 1'b1;
                    alu_src_imm = 1'b1;
                end
                StExeB: begin
                    alu_en      = 1'b1;
                    branch_eval = 1'b1;
                end
                StWbR:  reg_write = 1'b1;
                StWbI: begin
                    reg_write = 1'b1;
                    dst_sel   = 2'b01;
                end
                StMemLw: begin
                    mem_read  = 1'b1;
                    mdr_write = mem_ready;
                end
                StMemSw: mem_write = 1'b1;
                StWbLw: begin
                    reg_write = 1'b1;
                    wb_sel    = 2'b01;
                    dst_sel   = 2'b01;
                end
                StWbJar: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    wb_sel    = 2'b10;
                    dst_sel   = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign state         = state_q;
    assign trigger       = trigger_q;
    assign retire        = retire_q;
    assign illegal_state = illegal_q;
    assign cycle_count   = cycle_q;
    assign instr_count   = instr_q;

endmodule
